osc_measure_ctrl: RTL
=====================

Name: osc_measure_ctrl

Overview:
Controller for the gated ring oscillator. It sequences the oscillator's enable and waits a settle time. It then counts oscillator rising edges over a programmable window of system-clock cycles and reports the count with a start/done handshake. It sits between the oscillator and any sequential logic that needs a frequency or delay measurement.

Parameters:
CNT_W, 16, width of edge counter and count output
WIN_W, 16, width of measurement-window length input
SETTLE_CYCLES, 4, clk cycles osc_en is high before counting starts (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a measurement; sampled only in IDLE
window  input  WIN_W  measurement length in clk cycles; latched on accepted start
osc_in  input  1  raw oscillator output, asynchronous to clk
osc_en  output  1  enable to oscillator
busy  output  1  high from accepted start until done cycle inclusive
done  output  1  one-cycle pulse: count/overflow valid
count  output  CNT_W  rising edges counted in last window; held until next accepted start
overflow  output  1  count saturated in last window; held with count

Behaviour:
- Reset (async, rst_n=0): state=IDLE. osc_en, busy, done, overflow = 0. count = 0. Synchronizer and edge-detect flops = 0. Settle/window counters = 0.
- osc_in passes through a 2-flop synchronizer, then a registered previous value; edge = sync & ~prev. Edges still in the synchronizer at the end of MEASURE are dropped.
- FSM states: IDLE, SETTLE, MEASURE, DONE.
- IDLE: busy=0, osc_en=0. When start=1 at edge k: latch window, clear count/overflow, go to SETTLE at k+1.
- SETTLE: osc_en=1, busy=1. Lasts exactly SETTLE_CYCLES cycles. Edges are ignored. Then MEASURE, or DONE directly if latched window==0.
- MEASURE: osc_en=1, busy=1. Lasts exactly window cycles. On each cycle with edge=1, count increments.
  - At count=2^CNT_W-1, count holds and overflow is set to 1 (sticky).
- DONE: osc_en=0, busy=1, done=1 for exactly one cycle. Then IDLE.
- Total latency from start edge to done: 1+SETTLE_CYCLES+window cycles.
- start while busy=1 is ignored, not queued. window changes after latch have no effect.
- Reset mid-operation: immediate return to reset values. No done pulse.
- Window counter is WIN_W wide and counts down from the latched value. There is no wrap: window=2^WIN_W-1 is legal.

Decomposition:
- Shared package osc_pkg holds the state encoding (IDLE=0, SETTLE=1, MEASURE=2, DONE=3) and the default SETTLE_CYCLES constant.
- One sub-module: osc_edge_sync (2-flop synchronizer plus rising-edge detect, async active-low reset). The FSM and counters stay in the top.

Test Plan:
- osc_in modelled as clk/4 square wave gated by osc_en, window=40 -> done at start+45 cycles, count=10, overflow=0, osc_en high for exactly 44 cycles.
- CNT_W=4, clk/4 oscillator, window=100 -> count=15, overflow=1, done pulse single cycle.
- window=0 -> osc_en high for 4 cycles, done at start+5, count=0, overflow=0.
- osc_in held 0, window=20 -> count=0. Second start with clk/4 oscillator -> count=5, proving count is cleared on start.
- start pulsed again during MEASURE, with window input changed to 8 -> ignored; original window length and count used; exactly one done.
- rst_n asserted mid-MEASURE -> osc_en, busy, count drop to 0 in the same cycle without waiting for clk; no done. A fresh start after release measures correctly.

Source files
------------

// File: rtl/osc_pkg.sv
// ---------------------------------------------------------------------------
// osc_pkg
// Shared definitions for the gated ring-oscillator measurement controller.
//   osc_state_e            : controller state encoding
//   SETTLE_CYCLES_DEFAULT  : default number of clk cycles the oscillator is
//                            enabled before edges are counted
// ---------------------------------------------------------------------------
package osc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } osc_state_e;

  localparam int unsigned SETTLE_CYCLES_DEFAULT = 4;

endpackage : osc_pkg

// File: rtl/osc_edge_sync.sv
// ---------------------------------------------------------------------------
// osc_edge_sync
// Brings the free-running oscillator output into the clk domain with a
// two-flop synchronizer, then flags a rising edge by comparing the
// synchronized value with its registered previous value.
// Ports:
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   async_i : raw oscillator output (asynchronous to clk)
//   sync_o  : synchronized oscillator level
//   rise_o  : one-cycle pulse on each synchronized rising edge
// ---------------------------------------------------------------------------
module osc_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // sync1_q may go metastable; only sync2_q is consumed downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign sync_o = sync2_q;
  assign rise_o = sync2_q & ~prev_q;

endmodule : osc_edge_sync

// File: rtl/osc_measure_ctrl.sv
// ---------------------------------------------------------------------------
// osc_measure_ctrl
// Sequences a gated ring oscillator: enables it, waits SETTLE_CYCLES clk
// cycles, counts its rising edges over a programmable window of clk cycles,
// then reports the (saturating) count with a one-cycle done pulse.
// Ports:
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : measurement request, only honoured while idle
//   window   : window length in clk cycles, captured on an accepted start
//   osc_in   : raw oscillator output, asynchronous to clk
//   osc_en   : oscillator enable (high during settle and measure)
//   busy     : high from accepted start through the done cycle
//   done     : one-cycle pulse, count/overflow valid
//   count    : rising edges seen in the last window, held until next start
//   overflow : count saturated during the last window, held with count
// ---------------------------------------------------------------------------
module osc_measure_ctrl
  import osc_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int WIN_W         = 16,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIN_W-1:0] window,
  input  logic             osc_in,
  output logic             osc_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  // Settle counter holds SETTLE_CYCLES-1 down to 0, so it never needs to
  // represent SETTLE_CYCLES itself.
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  osc_state_e       state_q,  state_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [WIN_W-1:0] win_q,    win_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             ovf_q,    ovf_d;

  logic osc_sync;
  logic osc_rise;

  osc_edge_sync u_edge_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (osc_in),
    .sync_o  (osc_sync),
    .rise_o  (osc_rise)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. The window counter is loaded with the full window and
  // the last measure cycle is the one where it reads 1, so a zero window
  // skips MEASURE entirely.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) begin
          state_d = (win_q == '0) ? ST_DONE : ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (win_q <= WIN_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode, purely from state so a reset drops the outputs at once.
  always_comb begin
    osc_en = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        osc_en = 1'b0;
        busy   = 1'b0;
      end
      ST_SETTLE, ST_MEASURE: begin
        osc_en = 1'b1;
        busy   = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        osc_en = 1'b0;
      end
    endcase
  end

  // Counter next values. Overflow is flagged when an edge arrives while the
  // count is already at its maximum, i.e. when an edge was actually lost.
  always_comb begin
    settle_d = settle_q;
    win_d    = win_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          settle_d = SETTLE_LAST;
          win_d    = window;
          count_d  = '0;
          ovf_d    = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (settle_q != '0) begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      ST_MEASURE: begin
        if (win_q != '0) begin
          win_d = win_q - WIN_W'(1);
        end
        if (osc_rise) begin
          if (count_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      default: begin
        settle_d = settle_q;
      end
    endcase
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_q <= '0;
      win_q    <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      settle_q <= settle_d;
      win_q    <= win_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign count    = count_q;
  assign overflow = ovf_q;

endmodule : osc_measure_ctrl
